// File: rtl/comp_pkg.sv
// comp_pkg: shared width, FSM state encoding and operand-select constants for the min/max sequencer
package comp_pkg;
    localparam int DATA_W = 16;
    typedef enum logic [2:0] {IDLE, FIRST, ACCEPT, CMP_MIN, CMP_MAX, DONE} state_t;
    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_MAX = 1'b1;
endpackage

// File: rtl/cmp_sub_share.sv
// cmp_sub_share: single time-shared subtractor, operand-B mux (min/max) and energy gating
//   en     in   subtractor enable (compare states only)
//   sel    in   SEL_MIN picks b_min, SEL_MAX picks b_max
//   a      in   hold register
//   b_min  in   running minimum
//   b_max  in   running maximum
//   lt     out  bit 15 of (a - b): "a less than b" under the wrap ordering
//   active out  energy enable seen by the subtractor
module cmp_sub_share import comp_pkg::*; (
    input  logic              en,
    input  logic              sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b_min,
    input  logic [DATA_W-1:0] b_max,
    output logic              lt,
    output logic              active
);
    logic [DATA_W-1:0] a_g, b_g, diff;
    // operands forced to zero when idle so the adder inputs do not toggle
    always_comb begin
        a_g    = en ? a : '0;
        b_g    = en ? (sel == SEL_MAX ? b_max : b_min) : '0;
        diff   = a_g - b_g;
        lt     = diff[DATA_W-1];
        active = en;
    end
endmodule

// File: rtl/comp_minmax_seq.sv
// comp_minmax_seq: streams a block of samples and tracks its running min/max with one shared subtractor
//   clk, rst          clock, asynchronous active-high reset
//   start, len        begin a block of len samples (sampled in IDLE)
//   abort             drop the block, back to IDLE without done
//   in_valid/in_data  sample input, in_ready accepts it
//   busy, done        not IDLE / one-cycle completion pulse
//   min_out, max_out  running minimum / maximum
//   cnt_out           samples consumed in this block
//   sub_active        subtractor energy enable
module comp_minmax_seq import comp_pkg::*; #(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
    output logic [LEN_W-1:0]  cnt_out,
    output logic              sub_active
);
    state_t            st, nxt;
    logic [LEN_W-1:0]  len_q, cnt_inc;
    logic [DATA_W-1:0] hold;
    logic              hs, cmp_en, lt;
    assign hs      = in_valid & in_ready;
    assign cnt_inc = cnt_out + LEN_W'(1);
    assign cmp_en  = st == CMP_MIN || st == CMP_MAX;
    cmp_sub_share u_sub (
        .en     (cmp_en),
        .sel    (st == CMP_MAX ? SEL_MAX : SEL_MIN),
        .a      (hold),
        .b_min  (min_out),
        .b_max  (max_out),
        .lt     (lt),
        .active (sub_active)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = start ? (len == '0 ? DONE : FIRST) : IDLE;
            FIRST:   nxt = hs ? (len_q == LEN_W'(1) ? DONE : ACCEPT) : FIRST;
            ACCEPT:  nxt = hs ? CMP_MIN : ACCEPT;
            CMP_MIN: nxt = CMP_MAX;
            CMP_MAX: nxt = cnt_inc == len_q ? DONE : ACCEPT;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end
    always_comb begin
        in_ready = st == FIRST || st == ACCEPT;
        busy     = st != IDLE;
        done     = st == DONE;
    end
    // abort suppresses every register update in its cycle, so partial results stay visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= '0;
            cnt_out <= '0;
            hold    <= '0;
            min_out <= '0;
            max_out <= '0;
        end else if (!abort) begin
            case (st)
                IDLE: if (start) begin
                    len_q   <= len;
                    cnt_out <= '0;
                    min_out <= '0;
                    max_out <= '0;
                end
                FIRST: if (in_valid) begin
                    min_out <= in_data;
                    max_out <= in_data;
                    cnt_out <= LEN_W'(1);
                end
                ACCEPT: if (in_valid) hold <= in_data;
                CMP_MIN: if (lt) min_out <= hold;
                CMP_MAX: begin
                    if (!lt) max_out <= hold;
                    cnt_out <= cnt_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_comp_minmax_seq.sv
// tb_comp_minmax_seq: scoreboard bench for comp_minmax_seq with directed and random blocks
module tb_comp_minmax_seq;
    logic        clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0;
    logic [7:0]  len = 0;
    logic [15:0] in_data = 0;
    logic        in_ready, busy, done, sub_active;
    logic [15:0] min_out, max_out;
    logic [7:0]  cnt_out;
    typedef struct {logic [15:0] mn; logic [15:0] mx; logic [7:0] c;} exp_t;
    exp_t        q[$];
    logic [15:0] sv[$];
    int          tests = 0, fails = 0, done_cnt = 0;
    logic        done_prev = 0, sa_seen = 0;
    comp_minmax_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
        .done(done), .min_out(min_out), .max_out(max_out), .cnt_out(cnt_out),
        .sub_active(sub_active)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    always @(negedge clk) begin
        if (rst) done_prev = 0;
        else begin
            if (sub_active) sa_seen = 1;
            if (done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("min_out", min_out, e.mn);
                    chk("max_out", max_out, e.mx);
                    chk("cnt_out", cnt_out, e.c);
                end
            end
            if (done && done_prev) begin
                fails++; $display("FAIL done_width: got 2+ cycles expected 1");
            end
            if (sub_active && (in_ready || !busy || done)) begin
                fails++; $display("FAIL sub_active_state: got 1 outside compare states");
            end
            if (in_ready && (!busy || done || sub_active)) begin
                fails++; $display("FAIL in_ready_state: got 1 outside FIRST/ACCEPT");
            end
            done_prev = done;
        end
    end
    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin @(posedge clk); #1; k++; end
        if (busy) begin tests++; fails++; $display("FAIL idle_timeout: got busy=1 expected 0"); end
    endtask
    task automatic do_start(input logic [7:0] l);
        wait_idle();
        start = 1; len = l;
        @(posedge clk); #1;
        start = 0;
    endtask
    task automatic send(input logic [15:0] d, input int gap);
        logic ok = 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1; in_data = d;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!ok) begin tests++; fails++; $display("FAIL handshake_timeout: got in_ready=0 expected 1"); end
    endtask
    task automatic run_block(input logic [7:0] l, input logic [15:0] mn, input logic [15:0] mx,
                             input int gapmax, input int dlat);
        exp_t e;
        e.mn = mn; e.mx = mx; e.c = l;
        q.push_back(e);
        do_start(l);
        foreach (sv[i]) send(sv[i], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
        if (dlat > 0) begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!done && n < 20);
            chk("done_latency", n, dlat);
            @(posedge clk); #1;
        end
        wait_idle();
    endtask
    function automatic logic lt16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        d = a - b;
        return d[15];
    endfunction
    initial begin
        logic [15:0] mn, mx, r;
        int d0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sub_active", sub_active, 0);
        chk("rst_min", min_out, 0);
        chk("rst_max", max_out, 0);
        chk("rst_cnt", cnt_out, 0);
        rst = 0;
        @(posedge clk); #1;
        sv = '{16'h0005, 16'hFFFD, 16'h0009, 16'h0002};
        run_block(4, 16'hFFFD, 16'h0009, 0, 3);
        sv = '{16'h7FFF, 16'h8000};
        run_block(2, 16'h7FFF, 16'h8000, 0, 3);
        sv = '{16'h8000, 16'h7FFF};
        run_block(2, 16'h7FFF, 16'h8000, 0, 3);
        sa_seen = 0;
        sv = '{16'h1234};
        run_block(1, 16'h1234, 16'h1234, 0, 1);
        chk("len1_sub_active", sa_seen, 0);
        sv = {};
        run_block(0, 16'h0000, 16'h0000, 0, 1);
        for (int b = 0; b < 4; b++) begin
            sv = '{16'h0010, 16'h0003, 16'h0020};
            run_block(3, 16'h0003, 16'h0020, 5, 0);
        end
        // start pulsed while the second sample is in CMP_MIN must be ignored
        q.push_back('{mn: 16'h0004, mx: 16'h0008, c: 8'd2});
        do_start(2);
        send(16'h0008, 0);
        send(16'h0004, 0);
        start = 1; len = 9;
        @(posedge clk); #1;
        start = 0;
        wait_idle();
        // abort in ACCEPT: partial values kept, no done
        d0 = done_cnt;
        do_start(3);
        send(16'h0042, 0);
        abort = 1; in_valid = 1; in_data = 16'h0001;
        @(posedge clk); #1;
        abort = 0; in_valid = 0;
        chk("abort_busy", busy, 0);
        chk("abort_cnt", cnt_out, 1);
        chk("abort_min", min_out, 16'h0042);
        chk("abort_max", max_out, 16'h0042);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        // reset asserted while in CMP_MAX
        do_start(2);
        send(16'h0011, 0);
        send(16'h0022, 0);
        @(posedge clk); #1;
        chk("cmpmax_sub_active", sub_active, 1);
        rst = 1; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sub_active", sub_active, 0);
        chk("mid_rst_min", min_out, 0);
        chk("mid_rst_max", max_out, 0);
        chk("mid_rst_cnt", cnt_out, 0);
        @(posedge clk); #1;
        rst = 0;
        for (int b = 0; b < 200; b++) begin
            int l;
            l = $urandom_range(0, 6);
            sv = {};
            mn = 0; mx = 0;
            for (int i = 0; i < l; i++) begin
                case ($urandom_range(0, 5))
                    0: r = 16'h7FFF;
                    1: r = 16'h8000;
                    2: r = 16'h0000;
                    3: r = 16'hFFFF;
                    default: r = 16'($urandom);
                endcase
                sv.push_back(r);
                if (i == 0) begin mn = r; mx = r; end
                else begin
                    if (lt16(r, mn)) mn = r;
                    if (!lt16(r, mx)) mx = r;
                end
            end
            run_block(8'(l), mn, mx, 2, 0);
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
